// File: rtl/pingpong_pkg.sv
// Shared types and default constants for the HPS ping-pong responder.
// Optional feature macro used by the top: PINGPONG_TIMEOUT_EN (idle watchdog).
package pingpong_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        RESPOND = 2'd2
    } pp_state_t;

    localparam int PP_DELAY_DEFAULT = 16;
    localparam int PP_CNT_W_DEFAULT = 16;

    // The delay counter is sized for the largest legal DELAY_CYCLES value.
    localparam int PP_DELAY_CNT_W = 16;

endpackage

// File: rtl/pingpong_sync.sv
// Two flip-flop synchroniser for the asynchronous ping line.
// Both stages reset to 0, so a high ping after reset is seen as a fresh request.
module pingpong_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    // Shift the async input through two stages to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/pingpong_responder.sv
// FPGA-side partner of the HPS ping-pong link: each ping toggle is answered,
// after DELAY_CYCLES, by pong taking the same level. Counts completed rounds
// and flags retracted pings (overrun).
// Optional feature macro: PINGPONG_TIMEOUT_EN builds an idle watchdog that
// sets timeout_o; without it timeout_o is tied to 0.
module pingpong_responder
    import pingpong_pkg::*;
#(
    parameter int DELAY_CYCLES   = PP_DELAY_DEFAULT,
    parameter int CNT_W          = PP_CNT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             ping_i,
    output logic             pong_o,
    output logic [CNT_W-1:0] round_count_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             timeout_o
);

    localparam logic [PP_DELAY_CNT_W-1:0] DELAY_LOAD = PP_DELAY_CNT_W'(DELAY_CYCLES - 1);

    logic                      ping_s2;
    logic                      pending;
    pp_state_t                 state;
    pp_state_t                 state_next;
    logic [PP_DELAY_CNT_W-1:0] delay_cnt;
    logic [PP_DELAY_CNT_W-1:0] delay_cnt_next;
    logic                      pong_next;
    logic [CNT_W-1:0]          count_next;
    logic                      overrun_set;

    pingpong_sync u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (ping_i),
        .q     (ping_s2)
    );

    assign pending = ping_s2 ^ pong_o;
    assign busy_o  = (state != IDLE);

    // Next-state, delay countdown and response decisions for the handshake FSM.
    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        pong_next      = pong_o;
        count_next     = round_count_o;
        overrun_set    = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i && pending) begin
                    state_next     = DELAY;
                    delay_cnt_next = DELAY_LOAD;
                end
            end
            DELAY: begin
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (!pending) begin
                    overrun_set = 1'b1;
                    state_next  = IDLE;
                end else if (delay_cnt == '0) begin
                    state_next = RESPOND;
                end else begin
                    delay_cnt_next = delay_cnt - PP_DELAY_CNT_W'(1);
                end
            end
            RESPOND: begin
                pong_next  = ping_s2;
                count_next = round_count_o + CNT_W'(1);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, delay counter, pong level and round counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            delay_cnt     <= '0;
            pong_o        <= 1'b0;
            round_count_o <= '0;
        end else begin
            state         <= state_next;
            delay_cnt     <= delay_cnt_next;
            pong_o        <= pong_next;
            round_count_o <= count_next;
        end
    end

    // Sticky overrun flag; a new overrun wins over a simultaneous clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overrun_o <= 1'b0;
        end else if (overrun_set) begin
            overrun_o <= 1'b1;
        end else if (clear_i) begin
            overrun_o <= 1'b0;
        end
    end

`ifdef PINGPONG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;
    logic            wd_fire;

    assign wd_run  = (state == IDLE) && enable_i && !pending;
    assign wd_fire = wd_run && (wd_cnt == WD_LAST);

    // Idle watchdog: counts quiet enabled IDLE cycles, restarts when it fires.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wd_cnt <= '0;
        end else if (!wd_run || wd_fire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Sticky timeout flag; a watchdog expiry wins over a simultaneous clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            timeout_o <= 1'b0;
        end else if (wd_fire) begin
            timeout_o <= 1'b1;
        end else if (clear_i) begin
            timeout_o <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_responder.sv
// Scoreboard bench for pingpong_responder: stimulus pushes expected
// {pong, round_count} responses, a negedge monitor pops and compares them.
module tb_pingpong_responder;

    localparam int D = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        enable_i;
    logic        clear_i;
    logic        ping_i;
    logic        pong_o;
    logic [15:0] round_count_o;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;

    logic        w_pong;
    logic [1:0]  w_count;
    logic        w_busy;
    logic        w_overrun;
    logic        w_timeout;

    int          compared   = 0;
    int          mismatched = 0;
    int          model_count = 0;
    logic [16:0] exp_q[$];
    logic        prev_pong;
    logic [15:0] prev_count;
    logic        lvl;
    logic        expect_to;

    always #5 clk_clk = ~clk_clk;

    pingpong_responder #(
        .DELAY_CYCLES   (D),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .ping_i        (ping_i),
        .pong_o        (pong_o),
        .round_count_o (round_count_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o)
    );

    pingpong_responder #(
        .DELAY_CYCLES (D),
        .CNT_W        (2)
    ) dut_wrap (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .ping_i        (ping_i),
        .pong_o        (w_pong),
        .round_count_o (w_count),
        .busy_o        (w_busy),
        .overrun_o     (w_overrun),
        .timeout_o     (w_timeout)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ping, input logic en, input logic clr);
        ping_i   = ping;
        enable_i = en;
        clear_i  = clr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic expectRound(input logic level);
        model_count++;
        exp_q.push_back({level, 16'(model_count)});
    endtask

    task automatic waitPong(input logic level, input string name);
        int k;
        k = 0;
        while (pong_o !== level && k < 40) begin
            step(1);
            k++;
        end
        checkOutput(name, {31'b0, pong_o}, {31'b0, level});
    endtask

    // Monitor: every change of pong/round_count must match the next queued response.
    always @(negedge clk_clk) begin
        logic [16:0] e;
        if (reset_reset_n !== 1'b1) begin
            prev_pong  = pong_o;
            prev_count = round_count_o;
        end else if (pong_o !== prev_pong || round_count_o !== prev_count) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_response", {15'b0, pong_o, round_count_o},
                            {15'b0, prev_pong, prev_count});
            end else begin
                e = exp_q.pop_front();
                checkOutput("response", {15'b0, pong_o, round_count_o}, {15'b0, e});
            end
            prev_pong  = pong_o;
            prev_count = round_count_o;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_time_limit reached");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
`ifdef PINGPONG_TIMEOUT_EN
        expect_to = 1'b1;
`else
        expect_to = 1'b0;
`endif
        reset_reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(2);

        // Reset state
        checkOutput("reset_pong",    {31'b0, pong_o},    0);
        checkOutput("reset_count",   {16'b0, round_count_o}, 0);
        checkOutput("reset_busy",    {31'b0, busy_o},    0);
        checkOutput("reset_overrun", {31'b0, overrun_o}, 0);
        checkOutput("reset_timeout", {31'b0, timeout_o}, 0);
        reset_reset_n = 1'b1;
        step(1);

        // Watchdog: 100 quiet enabled cycles
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(99);
        checkOutput("wd_before_limit", {31'b0, timeout_o}, 0);
        step(1);
        checkOutput("wd_at_limit", {31'b0, timeout_o}, {31'b0, expect_to});
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wd_clear", {31'b0, timeout_o}, 0);

        // Basic round: busy on edges 3..7, pong rises on edge 8
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectRound(1'b1);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            checkOutput($sformatf("basic_busy_e%0d", e), {31'b0, busy_o},
                        (e >= 3 && e <= 7) ? 32'd1 : 32'd0);
            if (e == 7) checkOutput("basic_pong_e7", {31'b0, pong_o}, 0);
            if (e == 8) checkOutput("basic_pong_e8", {31'b0, pong_o}, 1);
        end
        checkOutput("basic_count", {16'b0, round_count_o}, 1);

        // Back-to-back rounds, wrap DUT tracks the count modulo 4
        lvl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lvl = ~lvl;
            applyStimulus(lvl, 1'b1, 1'b0);
            expectRound(lvl);
            waitPong(lvl, $sformatf("b2b_pong_%0d", i));
            checkOutput($sformatf("wrap_count_%0d", i), {30'b0, w_count}, {30'b0, 2'(model_count)});
        end
        checkOutput("b2b_count",   {16'b0, round_count_o}, 11);
        checkOutput("b2b_overrun", {31'b0, overrun_o}, 0);

        // Overrun: retract ping 3 cycles after toggling; set beats clear on edge 6
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(2);
        checkOutput("overrun_not_yet", {31'b0, overrun_o}, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("overrun_set_beats_clear", {31'b0, overrun_o}, 1);
        checkOutput("overrun_busy",  {31'b0, busy_o}, 0);
        checkOutput("overrun_pong",  {31'b0, pong_o}, 1);
        checkOutput("overrun_count", {16'b0, round_count_o}, 11);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("overrun_clear", {31'b0, overrun_o}, 0);

        // Disable mid-delay, then re-enable with ping still low
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(4);
        checkOutput("dis_in_delay", {31'b0, busy_o}, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(1);
        checkOutput("dis_idle_busy", {31'b0, busy_o}, 0);
        step(4);
        checkOutput("dis_pong_held", {31'b0, pong_o}, 1);
        checkOutput("dis_overrun",   {31'b0, overrun_o}, 0);
        checkOutput("dis_timeout",   {31'b0, timeout_o}, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectRound(1'b0);
        step(1);
        step(D);
        checkOutput("reen_pong_before", {31'b0, pong_o}, 1);
        step(1);
        checkOutput("reen_pong_after", {31'b0, pong_o}, 0);

        // Reset asserted mid-DELAY with pong high
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectRound(1'b1);
        waitPong(1'b1, "pre_reset_round");
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(4);
        checkOutput("pre_reset_busy", {31'b0, busy_o}, 1);
        reset_reset_n = 1'b0;
        #1;
        checkOutput("midrst_pong",    {31'b0, pong_o},    0);
        checkOutput("midrst_count",   {16'b0, round_count_o}, 0);
        checkOutput("midrst_busy",    {31'b0, busy_o},    0);
        checkOutput("midrst_overrun", {31'b0, overrun_o}, 0);
        checkOutput("midrst_timeout", {31'b0, timeout_o}, 0);
        checkOutput("midrst_wrap",    {30'b0, w_count},   0);
        model_count = 0;
        step(2);
        reset_reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectRound(1'b1);
        waitPong(1'b1, "post_reset_round");
        checkOutput("post_reset_count", {16'b0, round_count_o}, 1);

        step(2);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
